id_operand_resolver: RTL and testbench

- Parametrised decode-stage operand resolution and hazard controller; successor to the decode stage's fixed single-case jump-register forward/stall logic and syscall bubble counter.
- Sits between the register file read ports and the EXE pipeline register.
- Resolves rs/rt operands from NUM_FWD in-flight producers (youngest first) and stalls when a needed producer has no data yet.
- Serialises syscalls with a configurable bubble drain and a one-cycle notify pulse.

---
 rtl/id_operand_resolver_pkg.sv | 15 +
 rtl/id_operand_resolver_if.sv | 45 ++++
 rtl/id_operand_resolver_fwd_select.sv | 43 ++++
 rtl/id_operand_resolver.sv | 88 ++++++++
 tb/tb_id_operand_resolver.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/id_operand_resolver_pkg.sv
// Shared definitions for decode-stage operand resolution: FSM encoding and
// the forwarding-source index convention (index 0 is the youngest producer).
package id_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_DRAIN  = 2'd1;
  localparam state_t ST_NOTIFY = 2'd2;

  localparam int FWD_EXE = 0;
  localparam int FWD_MEM = 1;
  localparam int FWD_WB  = 2;

endpackage

// File: rtl/id_operand_resolver_if.sv
// Signal bundle between decode, the forwarding network and the EXE register.
interface id_operand_resolver_if #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int NUM_FWD = 3
);
  import id_pkg::*;

  // fwd_valid[i] qualifies fwd_reg slice i; fwd_ready[i] qualifies fwd_data
  // slice i; the decode slot advances on a cycle with id_valid & ~want_freeze.
  logic                      id_valid;
  logic [REG_AW-1:0]         rs_addr;
  logic [REG_AW-1:0]         rt_addr;
  logic                      rs_used;
  logic                      rt_used;
  logic [DATA_W-1:0]         rs_rf_data;
  logic [DATA_W-1:0]         rt_rf_data;
  logic                      is_sys;
  logic                      sys_notify_en;
  logic [NUM_FWD-1:0]        fwd_valid;
  logic [NUM_FWD*REG_AW-1:0] fwd_reg;
  logic [NUM_FWD-1:0]        fwd_ready;
  logic [NUM_FWD*DATA_W-1:0] fwd_data;
  logic [DATA_W-1:0]         rs_val;
  logic [DATA_W-1:0]         rt_val;
  logic                      want_freeze;
  logic [DATA_W-1:0]         rs_val_q;
  logic [DATA_W-1:0]         rt_val_q;
  logic                      issue_q;
  logic                      sys_q;
  state_t                    dbg_state;

  modport master (
    output id_valid, rs_addr, rt_addr, rs_used, rt_used, rs_rf_data, rt_rf_data,
           is_sys, sys_notify_en, fwd_valid, fwd_reg, fwd_ready, fwd_data,
    input  rs_val, rt_val, want_freeze, rs_val_q, rt_val_q, issue_q, sys_q, dbg_state
  );

  modport slave (
    input  id_valid, rs_addr, rt_addr, rs_used, rt_used, rs_rf_data, rt_rf_data,
           is_sys, sys_notify_en, fwd_valid, fwd_reg, fwd_ready, fwd_data,
    output rs_val, rt_val, want_freeze, rs_val_q, rt_val_q, issue_q, sys_q, dbg_state
  );

endinterface

// File: rtl/id_operand_resolver_fwd_select.sv
// Priority forwarding mux for one source operand: youngest matching producer
// wins, and a hazard is raised when that producer has no data yet.
module fwd_select #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int NUM_FWD = 3
) (
  input  logic [REG_AW-1:0]         addr,
  input  logic                      used,
  input  logic [DATA_W-1:0]         rf_data,
  input  logic [NUM_FWD-1:0]        fwd_valid,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_reg,
  input  logic [NUM_FWD-1:0]        fwd_ready,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
  output logic [DATA_W-1:0]         val,
  output logic                      hazard
);

  logic hit;
  logic hit_ready;

  // Scan oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    val       = rf_data;
    hit       = 1'b0;
    hit_ready = 1'b1;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (fwd_valid[i] && (fwd_reg[i*REG_AW +: REG_AW] == addr)) begin
        hit       = 1'b1;
        hit_ready = fwd_ready[i];
        val       = fwd_data[i*DATA_W +: DATA_W];
      end
    end
    if (addr == '0) begin
      val       = '0;
      hit       = 1'b0;
      hit_ready = 1'b1;
    end
  end

  assign hazard = used & hit & ~hit_ready;

endmodule

// File: rtl/id_operand_resolver.sv
// Decode-stage operand resolution, load-use stall and syscall serialisation
// (bubble drain followed by a one-cycle notify pulse).
module id_operand_resolver
  import id_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 5,
  parameter int NUM_FWD     = 3,
  parameter int SYS_BUBBLES = 3
) (
  input logic CLK,
  input logic RESET,
  id_operand_resolver_if.slave bus
);

  if (SYS_BUBBLES < 1 || SYS_BUBBLES > 7) begin : g_bad_bubbles
    $error("SYS_BUBBLES must be within 1..7");
  end

  localparam logic [2:0] CNT_INIT = 3'(SYS_BUBBLES - 1);

  state_t            state;
  logic [2:0]        cnt;
  logic [DATA_W-1:0] rs_res;
  logic [DATA_W-1:0] rt_res;
  logic              rs_haz;
  logic              rt_haz;
  logic              hazard;
  logic              freeze;
  logic              issue;

  fwd_select #(.DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_FWD(NUM_FWD)) u_rs_sel (
    .addr(bus.rs_addr), .used(bus.rs_used), .rf_data(bus.rs_rf_data),
    .fwd_valid(bus.fwd_valid), .fwd_reg(bus.fwd_reg), .fwd_ready(bus.fwd_ready),
    .fwd_data(bus.fwd_data), .val(rs_res), .hazard(rs_haz)
  );

  fwd_select #(.DATA_W(DATA_W), .REG_AW(REG_AW), .NUM_FWD(NUM_FWD)) u_rt_sel (
    .addr(bus.rt_addr), .used(bus.rt_used), .rf_data(bus.rt_rf_data),
    .fwd_valid(bus.fwd_valid), .fwd_reg(bus.fwd_reg), .fwd_ready(bus.fwd_ready),
    .fwd_data(bus.fwd_data), .val(rt_res), .hazard(rt_haz)
  );

  assign hazard = bus.id_valid & (rs_haz | rt_haz);
  // A syscall freezes from its first IDLE cycle, even while it also has a hazard.
  assign freeze = bus.id_valid &
                  (hazard | ((state == ST_IDLE) & bus.is_sys) | (state == ST_DRAIN));
  assign issue  = bus.id_valid & ~freeze;

  assign bus.rs_val      = rs_res;
  assign bus.rt_val      = rt_res;
  assign bus.want_freeze = freeze;
  assign bus.dbg_state   = state;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state        <= ST_IDLE;
      cnt          <= 3'd0;
      bus.issue_q  <= 1'b0;
      bus.sys_q    <= 1'b0;
      bus.rs_val_q <= '0;
      bus.rt_val_q <= '0;
    end else begin
      bus.issue_q  <= issue;
      bus.rs_val_q <= issue ? rs_res : '0;
      bus.rt_val_q <= issue ? rt_res : '0;
      bus.sys_q    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.id_valid && bus.is_sys && !hazard) begin
            state <= ST_DRAIN;
            cnt   <= CNT_INIT;
          end
        end
        ST_DRAIN: begin
          if (cnt == 3'd0) state <= ST_NOTIFY;
          else             cnt   <= cnt - 3'd1;
        end
        ST_NOTIFY: begin
          bus.sys_q <= bus.sys_notify_en;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_id_operand_resolver.sv
// Directed bench for id_operand_resolver: forwarding vector table plus
// syscall drain, back-to-back, hazard-wait and reset-mid-drain sequences.
module tb_id_operand_resolver;
  import id_pkg::*;

  logic CLK;
  logic RESET;
  int   checks;
  int   failures;

  id_operand_resolver_if #(.DATA_W(32), .REG_AW(5), .NUM_FWD(3)) bus ();

  id_operand_resolver #(.DATA_W(32), .REG_AW(5), .NUM_FWD(3), .SYS_BUBBLES(3)) dut (
    .CLK(CLK), .RESET(RESET), .bus(bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        id_valid;
    logic [4:0]  rs, rt;
    logic        rs_used, rt_used;
    logic [31:0] rs_rf, rt_rf;
    logic [2:0]  fv;
    logic [14:0] fr;
    logic [2:0]  fy;
    logic [95:0] fd;
    logic [31:0] e_rs, e_rt;
    logic        e_frz, e_iss;
    logic [31:0] e_rsq, e_rtq;
  } vec_t;

  vec_t vecs[10];

  function automatic vec_t mk(
    input logic iv, input logic [4:0] rs, input logic [4:0] rt,
    input logic ru, input logic tu, input logic [31:0] rsf, input logic [31:0] rtf,
    input logic [2:0] fv, input logic [14:0] fr, input logic [2:0] fy, input logic [95:0] fd,
    input logic [31:0] ers, input logic [31:0] ert, input logic efz, input logic eis,
    input logic [31:0] ersq, input logic [31:0] ertq);
    vec_t v;
    v.id_valid = iv; v.rs = rs; v.rt = rt; v.rs_used = ru; v.rt_used = tu;
    v.rs_rf = rsf; v.rt_rf = rtf; v.fv = fv; v.fr = fr; v.fy = fy; v.fd = fd;
    v.e_rs = ers; v.e_rt = ert; v.e_frz = efz; v.e_iss = eis; v.e_rsq = ersq; v.e_rtq = ertq;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    bus.id_valid = 1'b0; bus.rs_addr = '0; bus.rt_addr = '0;
    bus.rs_used = 1'b0; bus.rt_used = 1'b0; bus.rs_rf_data = '0; bus.rt_rf_data = '0;
    bus.is_sys = 1'b0; bus.sys_notify_en = 1'b0;
    bus.fwd_valid = '0; bus.fwd_reg = '0; bus.fwd_ready = '0; bus.fwd_data = '0;
  endtask

  task automatic drive_vec(input vec_t v);
    bus.id_valid = v.id_valid; bus.rs_addr = v.rs; bus.rt_addr = v.rt;
    bus.rs_used = v.rs_used; bus.rt_used = v.rt_used;
    bus.rs_rf_data = v.rs_rf; bus.rt_rf_data = v.rt_rf;
    bus.is_sys = 1'b0; bus.sys_notify_en = 1'b0;
    bus.fwd_valid = v.fv; bus.fwd_reg = v.fr; bus.fwd_ready = v.fy; bus.fwd_data = v.fd;
  endtask

  // One full syscall: 4 frozen cycles, then the issuing NOTIFY cycle.
  // Entered just after a rising edge with the syscall already on the inputs.
  task automatic sys_pass(input string tag, input logic exp_sys);
    for (int k = 0; k < 4; k++) begin
      #4;
      chk({tag, "_freeze"}, 32'(bus.want_freeze), 32'd1);
      @(posedge CLK); #1;
      chk({tag, "_bubble_issue"}, 32'(bus.issue_q), 32'd0);
      chk({tag, "_bubble_sys"}, 32'(bus.sys_q), 32'd0);
    end
    #4;
    chk({tag, "_notify_freeze"}, 32'(bus.want_freeze), 32'd0);
    chk({tag, "_notify_state"}, 32'(bus.dbg_state), 32'(ST_NOTIFY));
    @(posedge CLK); #1;
    chk({tag, "_issue"}, 32'(bus.issue_q), 32'd1);
    chk({tag, "_sys_q"}, 32'(bus.sys_q), 32'(exp_sys));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    RESET    = 1'b0;
    drive_idle();

    vecs[0] = mk(1, 5'd8, 5'd0, 1, 0, 32'h1111, 32'h2222, 3'b110, {5'd8, 5'd8, 5'd0}, 3'b111,
                 {32'hBBBB, 32'hAAAA, 32'h0}, 32'hAAAA, 32'h0, 0, 1, 32'hAAAA, 32'h0);
    vecs[1] = mk(1, 5'd3, 5'd9, 1, 1, 32'h33, 32'h99, 3'b011, {5'd0, 5'd9, 5'd9}, 3'b010,
                 {32'h0, 32'h77, 32'h55}, 32'h33, 32'h55, 1, 0, 32'h0, 32'h0);
    vecs[2] = mk(1, 5'd3, 5'd9, 1, 1, 32'h33, 32'h99, 3'b011, {5'd0, 5'd9, 5'd9}, 3'b011,
                 {32'h0, 32'h77, 32'h55}, 32'h33, 32'h55, 0, 1, 32'h33, 32'h55);
    vecs[3] = mk(1, 5'd0, 5'd5, 1, 0, 32'hDEAD, 32'h5, 3'b001, {5'd0, 5'd0, 5'd0}, 3'b000,
                 {32'h0, 32'h0, 32'h1234}, 32'h0, 32'h5, 0, 1, 32'h0, 32'h5);
    vecs[4] = mk(1, 5'd4, 5'd6, 0, 1, 32'h44, 32'h66, 3'b001, {5'd0, 5'd0, 5'd4}, 3'b000,
                 {32'h0, 32'h0, 32'hC0DE}, 32'hC0DE, 32'h66, 0, 1, 32'hC0DE, 32'h66);
    vecs[5] = mk(0, 5'd3, 5'd9, 1, 1, 32'h33, 32'h99, 3'b011, {5'd0, 5'd9, 5'd9}, 3'b010,
                 {32'h0, 32'h77, 32'h55}, 32'h33, 32'h55, 0, 0, 32'h0, 32'h0);
    vecs[6] = mk(1, 5'd7, 5'd10, 1, 1, 32'h77, 32'hABCD, 3'b100, {5'd7, 5'd0, 5'd0}, 3'b100,
                 {32'hFEED, 32'h0, 32'h0}, 32'hFEED, 32'hABCD, 0, 1, 32'hFEED, 32'hABCD);
    vecs[7] = mk(1, 5'd12, 5'd13, 1, 1, 32'h0, 32'h0, 3'b111, {5'd13, 5'd12, 5'd1}, 3'b111,
                 {32'h13, 32'h12, 32'h01}, 32'h12, 32'h13, 0, 1, 32'h12, 32'h13);
    vecs[8] = mk(1, 5'd14, 5'd0, 1, 1, 32'h1414, 32'hAA, 3'b000, {5'd0, 5'd0, 5'd14}, 3'b111,
                 {32'h0, 32'h0, 32'h9}, 32'h1414, 32'h0, 0, 1, 32'h1414, 32'h0);
    vecs[9] = mk(1, 5'd20, 5'd0, 1, 0, 32'h2020, 32'h0, 3'b011, {5'd0, 5'd20, 5'd20}, 3'b001,
                 {32'h0, 32'hBAD, 32'h600D}, 32'h600D, 32'h0, 0, 1, 32'h600D, 32'h0);

    // Reset state.
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_issue_q", 32'(bus.issue_q), 32'd0);
    chk("rst_sys_q", 32'(bus.sys_q), 32'd0);
    chk("rst_rs_val_q", bus.rs_val_q, 32'd0);
    chk("rst_rt_val_q", bus.rt_val_q, 32'd0);
    chk("rst_state", 32'(bus.dbg_state), 32'(ST_IDLE));
    RESET = 1'b1;
    @(posedge CLK); #1;

    // Forwarding/stall table.
    for (int i = 0; i < 10; i++) begin
      drive_vec(vecs[i]);
      #4;
      chk($sformatf("v%0d_rs_val", i), bus.rs_val, vecs[i].e_rs);
      chk($sformatf("v%0d_rt_val", i), bus.rt_val, vecs[i].e_rt);
      chk($sformatf("v%0d_freeze", i), 32'(bus.want_freeze), 32'(vecs[i].e_frz));
      @(posedge CLK); #1;
      chk($sformatf("v%0d_issue_q", i), 32'(bus.issue_q), 32'(vecs[i].e_iss));
      chk($sformatf("v%0d_rs_val_q", i), bus.rs_val_q, vecs[i].e_rsq);
      chk($sformatf("v%0d_rt_val_q", i), bus.rt_val_q, vecs[i].e_rtq);
      chk($sformatf("v%0d_sys_q", i), 32'(bus.sys_q), 32'd0);
    end

    // Syscall with notify, then a back-to-back LL/SC that must not notify.
    drive_idle();
    bus.id_valid = 1'b1; bus.is_sys = 1'b1; bus.sys_notify_en = 1'b1;
    sys_pass("sys", 1'b1);
    bus.sys_notify_en = 1'b0;
    sys_pass("llsc", 1'b0);
    bus.is_sys = 1'b0;
    #4;
    chk("post_sys_freeze", 32'(bus.want_freeze), 32'd0);
    @(posedge CLK); #1;
    chk("post_sys_issue", 32'(bus.issue_q), 32'd1);
    chk("post_sys_sys_q", 32'(bus.sys_q), 32'd0);

    // Syscall blocked by a load-use hazard waits in IDLE, frozen.
    bus.is_sys = 1'b1; bus.sys_notify_en = 1'b1;
    bus.rt_used = 1'b1; bus.rt_addr = 5'd9;
    bus.fwd_valid = 3'b001; bus.fwd_reg = {5'd0, 5'd0, 5'd9}; bus.fwd_ready = 3'b000;
    for (int k = 0; k < 2; k++) begin
      #4;
      chk("haz_sys_freeze", 32'(bus.want_freeze), 32'd1);
      @(posedge CLK); #1;
      chk("haz_sys_state", 32'(bus.dbg_state), 32'(ST_IDLE));
      chk("haz_sys_issue", 32'(bus.issue_q), 32'd0);
    end
    bus.fwd_ready = 3'b001;
    sys_pass("haz_sys", 1'b1);
    drive_idle();
    @(posedge CLK); #1;

    // Reset asserted mid-drain (DRAIN with cnt=1), then a full restart.
    bus.id_valid = 1'b1; bus.is_sys = 1'b1; bus.sys_notify_en = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk("mid_state_drain", 32'(bus.dbg_state), 32'(ST_DRAIN));
    #2;
    RESET = 1'b0;
    #1;
    chk("mid_rst_state", 32'(bus.dbg_state), 32'(ST_IDLE));
    chk("mid_rst_issue", 32'(bus.issue_q), 32'd0);
    chk("mid_rst_sys", 32'(bus.sys_q), 32'd0);
    chk("mid_rst_freeze", 32'(bus.want_freeze), 32'd1);
    @(posedge CLK); #1;
    chk("mid_rst_hold_state", 32'(bus.dbg_state), 32'(ST_IDLE));
    RESET = 1'b1;
    sys_pass("restart", 1'b1);

    drive_idle();
    @(posedge CLK); #1;
    chk("final_sys_q", 32'(bus.sys_q), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
